// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control path and the multiply/divide unit.
// The control path drives the request side; the unit drives status and HI/LO.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] read_data_1;
  logic [WIDTH-1:0] read_data_2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, read_data_1, read_data_2, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, read_data_1, read_data_2, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS mult/multu/div/divu engine owning HI/LO; fixed 33-cycle latency.
// Magnitudes are iterated unsigned, sign correction is applied in the FIX state.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     m_sum, d_shift, d_sub;
  logic               d_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, rs_back;

  assign is_signed = ~bus.op[0];
  assign rs_neg    = is_signed & bus.read_data_1[WIDTH-1];
  assign rt_neg    = is_signed & bus.read_data_2[WIDTH-1];
  assign rs_abs    = rs_neg ? -bus.read_data_1 : bus.read_data_1;
  assign rt_abs    = rt_neg ? -bus.read_data_2 : bus.read_data_2;

  // Multiply: sh_q holds the multiplier, low product bits shift into its top.
  assign m_sum   = acc_q + (sh_q[0] ? {1'b0, opa_q} : '0);
  // Divide: sh_q holds the dividend, quotient bits shift into its bottom.
  assign d_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
  assign d_sub   = d_shift - {1'b0, opb_q};
  assign d_ge    = d_shift >= {1'b0, opb_q};

  assign prod     = {acc_q[WIDTH-1:0], sh_q};
  assign prod_fix = neg_p_q ? -prod : prod;
  assign quo_fix  = neg_p_q ? -sh_q : sh_q;
  assign rem_fix  = neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rs_back  = neg_r_q ? -opa_q : opa_q;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    dbz_d    = dbz_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          neg_p_d  = rs_neg ^ rt_neg;
          neg_r_d  = rs_neg;
          dbz_d    = bus.op[1] & (bus.read_data_2 == '0);
          opa_d    = rs_abs;
          opb_d    = rt_abs;
          acc_d    = '0;
          sh_d     = bus.op[1] ? rs_abs : rt_abs;
          cnt_d    = '0;
          state_d  = S_CALC;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = d_ge ? d_sub : d_shift;
          sh_d  = {sh_q[WIDTH-2:0], d_ge};
        end else begin
          acc_d = {1'b0, m_sum[WIDTH:1]};
          sh_d  = {m_sum[0], sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          if (dbz_q) begin
            lo_d = '1;
            hi_d = rs_back;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        dz_d    = dbz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dbz_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      dbz_q    <= dbz_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: results, latency, div-by-zero and handshake rules.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Issue one request, then count edges until done (bounded at 40).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.read_data_1 = a; bus.read_data_2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.read_data_1 = 32'hDEAD_BEEF; bus.read_data_2 = 32'h0BAD_F00D;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.hi !== 32'h0) $display("FAIL rst_hi: got %h exp 0", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'h0) $display("FAIL rst_lo: got %h exp 0", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b exp 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL rst_dbz: got %b exp 0", bus.div_by_zero); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_0000;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0000_5555;
    @(negedge clk); bus.lo_we = 1'b0;
    total_cnt++; if (bus.hi !== 32'hAAAA_0000) $display("FAIL preload_hi: got %h exp aaaa0000", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'h0000_5555) $display("FAIL preload_lo: got %h exp 00005555", bus.lo); else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.read_data_1 = 32'hFFFF_FFFD; bus.read_data_2 = 32'd7;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midop_busy: got %b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'h0) $display("FAIL midop_hi: got %h exp 0", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'h0) $display("FAIL midop_lo: got %h exp 0", bus.lo); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL postrst_busy: got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_multu();
    int cyc;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL multu_lat: got %0d exp 33", cyc); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h exp fffffffe", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h exp 00000001", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL multu_busy_at_done: got %b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL multu_dbz: got %b exp 0", bus.div_by_zero); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL multu_done_pulse: got %b exp 0", bus.done); else pass_cnt++;
  endtask

  task automatic test_mult();
    int cyc;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL mult_lat: got %0d exp 33", cyc); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h exp ffffffff", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'hFFFF_FFEB) $display("FAIL mult_neg_lo: got %h exp ffffffeb", bus.lo); else pass_cnt++;
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, cyc);
    total_cnt++; if (bus.hi !== 32'h4000_0000) $display("FAIL mult_min_hi: got %h exp 40000000", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'h0) $display("FAIL mult_min_lo: got %h exp 0", bus.lo); else pass_cnt++;
  endtask

  task automatic test_div();
    int cyc;
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL div_lat: got %0d exp 33", cyc); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_q: got %h exp fffffffd", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_r: got %h exp ffffffff", bus.hi); else pass_cnt++;
    issue(2'b11, 32'd100, 32'd7, cyc);
    total_cnt++; if (bus.lo !== 32'd14) $display("FAIL divu_q: got %h exp 0000000e", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'd2) $display("FAIL divu_r: got %h exp 00000002", bus.hi); else pass_cnt++;
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    total_cnt++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_q: got %h exp 80000000", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_r: got %h exp 0", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL div_ovf_dbz: got %b exp 0", bus.div_by_zero); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int cyc;
    issue(2'b11, 32'd55, 32'd0, cyc);
    total_cnt++; if (cyc !== 33) $display("FAIL dbz_lat: got %0d exp 33", cyc); else pass_cnt++;
    total_cnt++; if (bus.div_by_zero !== 1'b1) $display("FAIL dbz_flag: got %b exp 1", bus.div_by_zero); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL dbz_lo: got %h exp ffffffff", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'd55) $display("FAIL dbz_hi: got %h exp 00000037", bus.hi); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL dbz_pulse: got %b exp 0", bus.div_by_zero); else pass_cnt++;
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, cyc);
    total_cnt++; if (bus.div_by_zero !== 1'b1) $display("FAIL sdbz_flag: got %b exp 1", bus.div_by_zero); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'hFFFF_FFFB) $display("FAIL sdbz_hi: got %h exp fffffffb", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL sdbz_lo: got %h exp ffffffff", bus.lo); else pass_cnt++;
  endtask

  task automatic test_handshake();
    int n;
    // a/b: start held high across two ops, with a dropped mthi during the first.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.read_data_1 = 32'd3; bus.read_data_2 = 32'd4;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL hs_busy_e0: got %b exp 1", bus.busy); else pass_cnt++;
    bus.read_data_1 = 32'd5; bus.read_data_2 = 32'd6;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
      end else if (n == 6) begin
        bus.hi_we = 1'b0;
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFB) $display("FAIL hs_busy_hiwe: got %h exp fffffffb", bus.hi); else pass_cnt++;
      end
    end
    total_cnt++; if (n !== 33) $display("FAIL hs_op1_lat: got %0d exp 33", n); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'd12) $display("FAIL hs_op1_lo: got %h exp 0000000c", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'h0) $display("FAIL hs_op1_hi: got %h exp 0", bus.hi); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL hs_b2b_busy: got %b exp 1", bus.busy); else pass_cnt++;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++; if (n !== 33) $display("FAIL hs_op2_lat: got %0d exp 33", n); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'd30) $display("FAIL hs_op2_lo: got %h exp 0000001e", bus.lo); else pass_cnt++;
    // c: mthi in IDLE.
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    total_cnt++; if (bus.hi !== 32'h1234) $display("FAIL hs_idle_hiwe: got %h exp 00001234", bus.hi); else pass_cnt++;
    // d: start wins over a simultaneous mtlo.
    @(negedge clk);
    bus.start = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    bus.op = 2'b01; bus.read_data_1 = 32'd2; bus.read_data_2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    total_cnt++; if (bus.lo !== 32'd30) $display("FAIL hs_start_lowe_hold: got %h exp 0000001e", bus.lo); else pass_cnt++;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++; if (bus.lo !== 32'd6) $display("FAIL hs_start_lowe_lo: got %h exp 00000006", bus.lo); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'h0) $display("FAIL hs_start_lowe_hi: got %h exp 0", bus.hi); else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.read_data_1 = '0; bus.read_data_2 = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_handshake();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
